// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one 32-bit ALU among N_REQ requesters
// Grants one request, runs it through the ALU from latched operands, returns a tagged response.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  sel,
    output logic [31:0] res,
    output logic        z,
    output logic        c,
    output logic        v
);
    logic [32:0] sum;

    // c is the carry out of the adder; for sub it is set when no borrow occurs.
    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (sel)
            3'b000: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            3'b001: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = ~a;
            default: res = '0;
        endcase
        z = (res == 32'd0);
    end
endmodule

module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_opA,
    input  logic [32*N_REQ-1:0] req_opB,
    input  logic [3*N_REQ-1:0]  req_sel,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_res,
    output logic                rsp_z,
    output logic                rsp_c,
    output logic                rsp_v,
    output logic                rsp_err,
    output logic [15:0]         ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [2:0]      sel_q, sel_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_res_q, rsp_res_d;
    logic            rsp_z_q, rsp_z_d;
    logic            rsp_c_q, rsp_c_d;
    logic            rsp_v_q, rsp_v_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     ops_done_q, ops_done_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             found;
    int               idx;
    int               grant_int;

    logic [31:0] alu_res;
    logic        alu_z, alu_c, alu_v;
    logic        sel_illegal;

    alu u_alu (
        .a   (op_a_q),
        .b   (op_b_q),
        .sel (sel_q),
        .res (alu_res),
        .z   (alu_z),
        .c   (alu_c),
        .v   (alu_v)
    );

    assign sel_illegal = (sel_q > 3'd4);

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_int = 0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_int  = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sel_d       = sel_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_z_d     = rsp_z_q;
        rsp_c_d     = rsp_c_q;
        rsp_v_d     = rsp_v_q;
        rsp_err_d   = rsp_err_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d  = req_opA[32*grant_int +: 32];
                    op_b_d  = req_opB[32*grant_int +: 32];
                    sel_d   = req_sel[3*grant_int +: 3];
                    id_d    = grant_idx;
                    ptr_d   = IDW'((grant_int + 1) % N_REQ);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                if (sel_illegal) begin
                    rsp_res_d = '0;
                    rsp_z_d   = 1'b1;
                    rsp_c_d   = 1'b0;
                    rsp_v_d   = 1'b0;
                    rsp_err_d = 1'b1;
                end else begin
                    rsp_res_d = alu_res;
                    rsp_z_d   = alu_z;
                    rsp_c_d   = alu_c;
                    rsp_v_d   = alu_v;
                    rsp_err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sel_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_z_q     <= 1'b0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_z_q     <= rsp_z_d;
            rsp_c_q     <= rsp_c_d;
            rsp_v_q     <= rsp_v_d;
            rsp_err_q   <= rsp_err_d;
            ops_done_q  <= ops_done_d;
        end
    end

    // Grants are masked by rst so they vanish the moment reset is raised.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_opA;
    logic [32*N_REQ-1:0] req_opB;
    logic [3*N_REQ-1:0]  req_sel;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_res;
    logic                rsp_z, rsp_c, rsp_v, rsp_err;
    logic [15:0]         ops_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ops = 0;

    alu_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_opA   (req_opA),
        .req_opB   (req_opB),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_z     (rsp_z),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
        .rsp_err   (rsp_err),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        req_opA[32*id +: 32] = a;
        req_opB[32*id +: 32] = b;
        req_sel[3*id +: 3]   = s;
    endtask

    task automatic run_single(input string tag, input int id, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] s,
                              input logic [31:0] e_res, input logic e_z, input logic e_c,
                              input logic e_v, input logic e_err);
        load(id, a, b, s);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
        tick();
        req_valid = '0;
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_res"}, rsp_res, e_res);
        chk({tag, "_flags"}, {28'd0, rsp_err, rsp_z, rsp_c, rsp_v}, {28'd0, e_err, e_z, e_c, e_v});
        tick();
        exp_ops++;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ops_done"}, 32'(ops_done), 32'(exp_ops));
    endtask

    logic [31:0] held_res;
    int          rr_ids[5] = '{0, 1, 2, 3, 0};
    logic [31:0] rr_res[5] = '{32'hF000F000, 32'h0F0000F0, 32'hFFFFFFFF, 32'h00000000, 32'hF000F000};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_opA   = '0;
        req_opB   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_ops", 32'(ops_done), 32'd0);
        chk("rst_res", rsp_res, 32'd0);
        chk("rst_flags", {28'd0, rsp_err, rsp_z, rsp_c, rsp_v}, 32'd0);
        rst = 1'b0;
        tick();

        run_single("add_carry", 0, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_single("add_ovf", 2, 32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset so the pointer restarts at 0 for the round-robin sweep.
        rst = 1'b1;
        #1;
        chk("rst2_ops", 32'(ops_done), 32'd0);
        rst = 1'b0;
        exp_ops = 0;
        tick();

        load(0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b010);
        load(1, 32'h0F000000, 32'h000000F0, 3'b011);
        load(2, 32'h00000000, 32'h12345678, 3'b100);
        load(3, 32'h00000000, 32'h00000000, 3'b011);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d_grant", k), 32'(req_ready), 32'(1) << rr_ids[k]);
            tick();
            chk($sformatf("rr%0d_exec_ready", k), 32'(req_ready), 32'd0);
            tick();
            chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(rr_ids[k]));
            chk($sformatf("rr%0d_res", k), rsp_res, rr_res[k]);
            chk($sformatf("rr%0d_z", k), 32'(rsp_z), 32'(rr_res[k] == 32'd0));
            tick();
            exp_ops++;
        end
        req_valid = '0;
        chk("rr_ops", 32'(ops_done), 32'(exp_ops));

        run_single("illegal", 1, 32'h12345678, 32'h9ABCDEF0, 3'b101, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_single("sub_after", 1, 32'h00000005, 32'h00000003, 3'b001, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: response must hold while requester 3 waits.
        rsp_ready = 1'b0;
        load(0, 32'h12345678, 32'h11111111, 3'b000);
        load(3, 32'hA0A0A0A0, 32'h05050505, 3'b011);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_res", rsp_res, 32'h23456789);
        held_res  = rsp_res;
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_res", k), rsp_res, held_res);
            chk($sformatf("bp_hold%0d_id", k), 32'(rsp_id), 32'd0);
            chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        exp_ops++;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ops", 32'(ops_done), 32'(exp_ops));
        chk("bp_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk("bp3_id", 32'(rsp_id), 32'd3);
        chk("bp3_res", rsp_res, 32'hA5A5A5A5);
        tick();
        exp_ops++;
        chk("bp3_ops", 32'(ops_done), 32'(exp_ops));

        // Reset during EXEC.
        load(2, 32'h1, 32'h1, 3'b000);
        req_valid = 4'b0100;
        #1;
        chk("rx_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("rx_valid", 32'(rsp_valid), 32'd0);
        chk("rx_ready", 32'(req_ready), 32'd0);
        chk("rx_ops", 32'(ops_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rx_prio0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("rr_resp_valid", 32'(rsp_valid), 32'd1);

        // Reset during RESP.
        rst = 1'b1;
        #1;
        chk("rr_rst_valid", 32'(rsp_valid), 32'd0);
        chk("rr_rst_ops", 32'(ops_done), 32'd0);
        chk("rr_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rr_rst_prio0", 32'(req_ready), 32'h1);
        req_valid = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the 32-bit combinational `alu` among `N_REQ` requesters. A round-robin arbiter grants one requester at a time and latches its operands and opcode into registers that drive the `alu`. The block then registers the result and the `z`/`c`/`v` flags and returns them on a shared response channel tagged with the requester ID. It sits between the operand-producing units and the `alu`.

## Interface
- `N_REQ`, default 4, number of requesters (2..8).
- `IDW`, default 2, requester ID width, equal to clog2(`N_REQ`).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  bit i means requester i has an operation pending.
- `req_opA`  in  32*`N_REQ`  operand A for requester i, at bits [32i+31:32i].
- `req_opB`  in  32*`N_REQ`  operand B for requester i, same packing as `req_opA`.
- `req_sel`  in  3*`N_REQ`  opcode for requester i, at bits [3i+2:3i].
- `req_ready`  out  `N_REQ`  one-hot grant; zero or one bit is set.
- `rsp_valid`  out  1  response is held on the response channel.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  `IDW`  index of the requester that owns the response.
- `rsp_res`  out  32  registered result.
- `rsp_z`, `rsp_c`, `rsp_v`  out  1 each  registered flags.
- `rsp_err`  out  1  opcode was illegal.
- `ops_done`  out  16  count of completed responses; wraps at 0xFFFF to 0.

## Operation
- Opcode map: 000 add, 001 sub, 010 and, 011 or, 100 not (applied to opA). Codes 101, 110 and 111 are illegal.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - `req_ready` is the combinational round-robin pick among the set `req_valid` bits.
  - The search starts at index `ptr` and wraps modulo `N_REQ`.
  - If `req_valid` is all zero, `req_ready` is all zero.
  - On an edge where `req_valid[g] & req_ready[g]`:
    - latch opA, opB, sel and `g` into internal registers;
    - set `ptr` to (g+1) mod `N_REQ`;
    - go to EXEC.
- EXEC:
  - The `alu` inputs come only from the latched registers. Live request inputs are ignored.
  - At the next edge, capture `alu` `res`, `z`, `c`, `v` into the `rsp_*` registers and set `rsp_valid`.
  - If sel is illegal, capture `rsp_res`=0, `rsp_z`=1, `rsp_c`=0, `rsp_v`=0 and `rsp_err`=1 instead of the `alu` outputs. Otherwise `rsp_err`=0.
  - Go to RESP.
- RESP:
  - All `rsp_*` outputs hold stable while `rsp_valid`=1.
  - On an edge with `rsp_ready`=1: clear `rsp_valid`, increment `ops_done`, go to IDLE.
- `req_ready` is all zero in EXEC and RESP.
- The requester is not required to keep `req_valid` asserted after its acceptance edge.
- Flags are passed through from the `alu` unchanged; the block does not recompute them.
- Reset:
  - state goes to IDLE and `ptr` to 0;
  - `rsp_valid`, `rsp_err`, `rsp_z`, `rsp_c`, `rsp_v` go to 0;
  - `rsp_res` goes to 0, `rsp_id` to 0, `ops_done` to 0;
  - the latched operand registers go to 0.

## Timing
- Request accepted at edge k: EXEC occupies cycle k..k+1 and `rsp_valid` rises after edge k+1.
- Minimum latency is 2 cycles from acceptance to `rsp_valid`.
- Minimum repeat period is 3 cycles per operation, reached when `rsp_ready` is held at 1.
- `rsp_ready` asserted before `rsp_valid` has no effect. Only the edge where both are 1 completes the response.
- A request that is valid in IDLE but loses arbitration waits. Round-robin bounds the wait to `N_REQ`-1 other grants.
- Asserting `rst` at any time, including during EXEC or RESP:
  - drops `rsp_valid` and `req_ready` to 0 immediately, without waiting for an edge;
  - discards the in-flight operation;
  - leaves `ops_done` at 0.
- `ops_done` increments exactly once per completed response handshake.

## Test plan
- Reset, then requester 0 sends add 0xFFFFFFFF + 0x00000001 with `rsp_ready`=1 -> `req_ready`=0001 in the first cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_res`=0, z=1, c=1, v=0; `ops_done`=1.
- Requester 2 sends add 0x7FFFFFFF + 0x00000001 -> `rsp_res`=0x80000000, z=0, c=0, v=1, `rsp_id`=2.
- All four requesters hold `req_valid`=1111 with mixed and/or/not ops -> grants occur in order 0,1,2,3,0. `rsp_res` for and 0xF0F0F0F0 & 0xFF00FF00 is 0xF000F000; for not 0x0 it is 0xFFFFFFFF.
- Requester 1 sends sel=101 -> `rsp_err`=1, `rsp_res`=0, z=1, c=0, v=0; the next legal op gives `rsp_err`=0.
- Hold `rsp_ready`=0 for 5 cycles during RESP while requester 3 is valid -> all `rsp_*` outputs stable, `req_ready`=0000. Raise `rsp_ready` -> back to IDLE, then requester 3 is granted.
- Assert `rst` during EXEC, and separately during RESP -> `rsp_valid`=0 immediately, `ops_done`=0, `ptr` back to 0. After release, requester 0 has highest priority.
